game_sequencer: RTL and testbench

//  Parametrised successor to the fixed-rate control path. Generates N phase-locked tick strobes

---
 rtl/game_pkg.sv | 12 +
 rtl/button_conditioner.sv | 45 ++++
 rtl/game_sequencer.sv | 151 +++++++++++++++
 tb/tb_game_sequencer.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// Shared types for the game control path.
// Game-state encoding and horizontal step width.
package game_pkg;
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PLAY  = 2'd1,
    PAUSE = 2'd2,
    OVER  = 2'd3
  } game_state_t;

  localparam int DELTA_W = 9;
endpackage

// File: rtl/button_conditioner.sv
// Raw button to clean level: 2-FF sync, debounce, rising edge.
// level moves only after DEBOUNCE_CYCLES equal differing samples.
module button_conditioner #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic rise
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic          r_s1;
  logic          r_s2;
  logic [CW-1:0] r_cnt;
  logic          r_level;
  logic          r_rise;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1    <= 1'b0;
      r_s2    <= 1'b0;
      r_cnt   <= '0;
      r_level <= 1'b0;
      r_rise  <= 1'b0;
    end else begin
      r_s1   <= raw;
      r_s2   <= r_s1;
      r_rise <= 1'b0;
      if (r_s2 == r_level) begin
        r_cnt <= '0;
      end else if (r_cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
        r_cnt   <= '0;
        r_level <= r_s2;
        r_rise  <= r_s2;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign level = r_level;
  assign rise  = r_rise;
endmodule

// File: rtl/game_sequencer.sv
// Game control path: tick strobes, button conditioning,
// game-state FSM, horizontal step and saturating score.
module game_sequencer
  import game_pkg::*;
#(
  parameter int CLK             = 50000000,
  parameter int TICK_CHANNELS   = 2,
  parameter int TICK_RATE [TICK_CHANNELS] = '{360, 60},
  parameter logic [TICK_CHANNELS-1:0] TICK_GATED_MASK = 2'b01,
  parameter int EARTH           = 768,
  parameter int DOODLE_HEIGHT   = 80,
  parameter int MOVE_SPEED      = 4,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int OVER_HOLD_TICKS = 360,
  parameter int SCORE_W         = 20
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     button_left,
  input  logic                     button_right,
  input  logic                     button_start,
  input  logic [9:0]               doodle_y,
  input  logic                     world_shift,
  input  logic [7:0]               shift_amount,
  output logic [TICK_CHANNELS-1:0] tick,
  output logic [1:0]               game_state,
  output logic signed [DELTA_W-1:0] delta_x,
  output logic [SCORE_W-1:0]       score
);
  function automatic int f_max_period();
    int m;
    m = 2;
    for (int i = 0; i < TICK_CHANNELS; i++)
      if (CLK / TICK_RATE[i] > m) m = CLK / TICK_RATE[i];
    return m;
  endfunction

  localparam int CNT_W = $clog2(f_max_period());
  localparam int HW    = $clog2(OVER_HOLD_TICKS + 1);
  localparam logic [9:0] FELL_Y = 10'(EARTH - DOODLE_HEIGHT);
  localparam logic signed [DELTA_W-1:0] DX = DELTA_W'(MOVE_SPEED);

  game_state_t               r_state;
  logic signed [DELTA_W-1:0] r_dx;
  logic [SCORE_W-1:0]        r_score;
  logic [HW-1:0]             r_hold;

  logic [TICK_CHANNELS-1:0]  w_tick_raw;
  logic                      w_left;
  logic                      w_right;
  logic                      w_start;
  logic                      w_unused_rise_l;
  logic                      w_unused_rise_r;
  logic                      w_unused_start_lvl;
  logic                      w_fell;
  logic [SCORE_W:0]          w_sum;
  logic signed [DELTA_W-1:0] w_dir;

  // Counters free-run in every state so gating never shifts phase.
  for (genvar gi = 0; gi < TICK_CHANNELS; gi++) begin : g_tick
    localparam int P = CLK / TICK_RATE[gi];
    logic [CNT_W-1:0] r_cnt;

    if (P < 2) begin : g_bad
      $error("tick period must be at least 2 cycles");
    end

    always_ff @(posedge clk) begin
      if (rst || r_cnt == CNT_W'(P - 1)) r_cnt <= '0;
      else                               r_cnt <= r_cnt + 1'b1;
    end

    assign w_tick_raw[gi] = (r_cnt == CNT_W'(P - 1));
    assign tick[gi] = w_tick_raw[gi] &
      (~TICK_GATED_MASK[gi] | (r_state == PLAY));
  end

  button_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_left (
    .clk(clk), .rst(rst), .raw(button_left),
    .level(w_left), .rise(w_unused_rise_l)
  );

  button_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_right (
    .clk(clk), .rst(rst), .raw(button_right),
    .level(w_right), .rise(w_unused_rise_r)
  );

  button_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_start (
    .clk(clk), .rst(rst), .raw(button_start),
    .level(w_unused_start_lvl), .rise(w_start)
  );

  assign w_fell = (doodle_y > FELL_Y);
  assign w_sum  = {1'b0, r_score} + (SCORE_W + 1)'(shift_amount);

  always_comb begin
    w_dir = '0;
    unique case (1'b1)
      (w_left & ~w_right): w_dir = -DX;
      (w_right & ~w_left): w_dir = DX;
      default:             w_dir = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_dx    <= '0;
      r_score <= '0;
      r_hold  <= '0;
    end else begin
      if (r_state == PLAY && world_shift)
        r_score <= w_sum[SCORE_W] ? '1 : w_sum[SCORE_W-1:0];
      unique case (r_state)
        IDLE: begin
          if (w_start) begin
            r_state <= PLAY;
            r_score <= '0;
          end
        end
        PLAY: begin
          if (w_fell) begin
            r_state <= OVER;
            r_hold  <= '0;
            r_dx    <= '0;
          end else if (w_start) begin
            r_state <= PAUSE;
            r_dx    <= '0;
          end else if (w_tick_raw[0]) begin
            r_dx <= w_dir;
          end
        end
        PAUSE: begin
          if (w_start) r_state <= PLAY;
        end
        OVER: begin
          // hold_cnt follows channel 0 even though its output is masked here
          if (w_tick_raw[0] && r_hold < HW'(OVER_HOLD_TICKS))
            r_hold <= r_hold + 1'b1;
          if (w_start && r_hold >= HW'(OVER_HOLD_TICKS))
            r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign game_state = r_state;
  assign delta_x    = r_dx;
  assign score      = r_score;
endmodule

// File: tb/tb_game_sequencer.sv
// Directed bench for game_sequencer with small tick periods
// (P0=10, P1=100), 4-cycle debounce and an 8-bit score.
module tb_game_sequencer;
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_PLAY  = 2'd1;
  localparam logic [1:0] S_PAUSE = 2'd2;
  localparam logic [1:0] S_OVER  = 2'd3;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              button_left = 1'b0;
  logic              button_right = 1'b0;
  logic              button_start = 1'b0;
  logic [9:0]        doodle_y = 10'd100;
  logic              world_shift = 1'b0;
  logic [7:0]        shift_amount = 8'd0;
  logic [1:0]        tick;
  logic [1:0]        game_state;
  logic signed [8:0] delta_x;
  logic [7:0]        score;

  int total = 0;
  int bad = 0;

  game_sequencer #(
    .CLK(1000),
    .TICK_CHANNELS(2),
    .TICK_RATE('{100, 10}),
    .TICK_GATED_MASK(2'b01),
    .EARTH(768),
    .DOODLE_HEIGHT(80),
    .MOVE_SPEED(4),
    .DEBOUNCE_CYCLES(4),
    .OVER_HOLD_TICKS(3),
    .SCORE_W(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .button_left(button_left),
    .button_right(button_right),
    .button_start(button_start),
    .doodle_y(doodle_y),
    .world_shift(world_shift),
    .shift_amount(shift_amount),
    .tick(tick),
    .game_state(game_state),
    .delta_x(delta_x),
    .score(score)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic press_start();
    @(negedge clk);
    button_start = 1'b1;
    repeat (10) @(negedge clk);
    button_start = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  task automatic pulse_shift(input logic [7:0] amt);
    @(negedge clk);
    world_shift = 1'b1;
    shift_amount = amt;
    @(negedge clk);
    world_shift = 1'b0;
    shift_amount = 8'd0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    total++;
    if ({game_state, tick} !== 4'b0 ||
        delta_x !== 9'sd0 || score !== 8'd0) begin
      bad++;
      $display("FAIL reset: state=%0d tick=%b dx=%0d score=%0d, want 0/00/0/0",
               game_state, tick, delta_x, score);
    end
    rst = 1'b0;
  endtask

  // Entered on the negedge right after the last reset edge (cycle 1).
  task automatic test_idle_ticks();
    logic [1:0] exp;
    for (int n = 1; n <= 250; n++) begin
      if (n > 1) @(negedge clk);
      exp = {(n % 100 == 0), 1'b0};
      total++;
      if (tick !== exp || game_state !== S_IDLE) begin
        bad++;
        $display("FAIL idle_tick c%0d: tick=%b state=%0d, want %b/0",
                 n, tick, game_state, exp);
      end
    end
  endtask

  task automatic test_glitch();
    @(negedge clk);
    button_start = 1'b1;
    repeat (2) @(negedge clk);
    button_start = 1'b0;
    repeat (12) @(negedge clk);
    total++;
    if (game_state !== S_IDLE) begin
      bad++;
      $display("FAIL glitch: state=%0d, want %0d", game_state, S_IDLE);
    end
  endtask

  task automatic test_start();
    logic [1:0] exp;
    @(negedge clk);
    button_start = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      exp = (k >= 7) ? S_PLAY : S_IDLE;
      total++;
      if (game_state !== exp) begin
        bad++;
        $display("FAIL start_lat k=%0d: state=%0d, want %0d",
                 k, game_state, exp);
      end
    end
    button_start = 1'b0;
    repeat (10) @(negedge clk);
    total++;
    if (game_state !== S_PLAY || score !== 8'd0) begin
      bad++;
      $display("FAIL start_once: state=%0d score=%0d, want %0d/0",
               game_state, score, S_PLAY);
    end
  endtask

  task automatic test_move();
    logic              tl [3] = '{1'b0, 1'b1, 1'b1};
    logic              tr [3] = '{1'b1, 1'b1, 1'b0};
    logic signed [8:0] te [3] = '{9'sd4, 9'sd0, -9'sd4};
    bit                seen;
    for (int v = 0; v < 3; v++) begin
      @(negedge clk);
      button_left = tl[v];
      button_right = tr[v];
      repeat (8) @(negedge clk);
      seen = 1'b0;
      for (int k = 0; k < 25 && !seen; k++) begin
        @(negedge clk);
        if (tick[0]) seen = 1'b1;
      end
      @(negedge clk);
      total++;
      if (!seen || delta_x !== te[v]) begin
        bad++;
        $display("FAIL move v%0d: tick_seen=%0b dx=%0d, want 1/%0d",
                 v, seen, delta_x, te[v]);
      end
    end
    @(negedge clk);
    button_start = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 12 && !seen; k++) begin
      @(negedge clk);
      if (game_state !== S_PLAY) seen = 1'b1;
    end
    total++;
    if (game_state !== S_PAUSE || delta_x !== 9'sd0) begin
      bad++;
      $display("FAIL pause_dx: state=%0d dx=%0d, want %0d/0",
               game_state, delta_x, S_PAUSE);
    end
    button_start = 1'b0;
    button_left = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  task automatic test_score();
    logic [7:0] amt [3] = '{8'd12, 8'd200, 8'd100};
    logic [7:0] exp [3] = '{8'd12, 8'd212, 8'd255};
    pulse_shift(8'd12);
    total++;
    if (score !== 8'd0) begin
      bad++;
      $display("FAIL score_pause0: score=%0d, want 0", score);
    end
    press_start();
    for (int i = 0; i < 3; i++) begin
      pulse_shift(amt[i]);
      total++;
      if (score !== exp[i] || game_state !== S_PLAY) begin
        bad++;
        $display("FAIL score_add%0d: score=%0d state=%0d, want %0d/%0d",
                 i, score, game_state, exp[i], S_PLAY);
      end
    end
    press_start();
    pulse_shift(8'd5);
    total++;
    if (score !== 8'd255 || game_state !== S_PAUSE) begin
      bad++;
      $display("FAIL score_pause1: score=%0d state=%0d, want 255/%0d",
               score, game_state, S_PAUSE);
    end
    press_start();
  endtask

  task automatic test_over();
    int t0;
    @(negedge clk);
    doodle_y = 10'd688;
    repeat (3) @(negedge clk);
    total++;
    if (game_state !== S_PLAY) begin
      bad++;
      $display("FAIL fell_edge: state=%0d, want %0d", game_state, S_PLAY);
    end
    button_start = 1'b1;
    repeat (6) @(negedge clk);
    total++;
    if (game_state !== S_PLAY) begin
      bad++;
      $display("FAIL over_pre: state=%0d, want %0d", game_state, S_PLAY);
    end
    doodle_y = 10'd689;
    @(negedge clk);
    total++;
    if (game_state !== S_OVER || delta_x !== 9'sd0) begin
      bad++;
      $display("FAIL over_prio: state=%0d dx=%0d, want %0d/0",
               game_state, delta_x, S_OVER);
    end
    button_start = 1'b0;
    repeat (6) @(negedge clk);
    button_start = 1'b1;
    repeat (8) @(negedge clk);
    total++;
    if (game_state !== S_OVER) begin
      bad++;
      $display("FAIL over_early: state=%0d, want %0d", game_state, S_OVER);
    end
    button_start = 1'b0;
    doodle_y = 10'd100;
    t0 = 0;
    repeat (40) begin
      @(negedge clk);
      if (tick[0]) t0++;
    end
    total++;
    if (t0 !== 0) begin
      bad++;
      $display("FAIL over_mask: tick0 count=%0d, want 0", t0);
    end
    press_start();
    total++;
    if (game_state !== S_IDLE || score !== 8'd255) begin
      bad++;
      $display("FAIL over_exit: state=%0d score=%0d, want %0d/255",
               game_state, score, S_IDLE);
    end
  endtask

  task automatic test_mid_reset();
    logic [1:0] exp_s;
    logic       exp_t;
    press_start();
    total++;
    if (game_state !== S_PLAY || score !== 8'd0) begin
      bad++;
      $display("FAIL replay_clear: state=%0d score=%0d, want %0d/0",
               game_state, score, S_PLAY);
    end
    pulse_shift(8'd40);
    press_start();
    total++;
    if (game_state !== S_PAUSE || score !== 8'd40) begin
      bad++;
      $display("FAIL pre_rst: state=%0d score=%0d, want %0d/40",
               game_state, score, S_PAUSE);
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    button_start = 1'b1;
    total++;
    if (game_state !== S_IDLE || score !== 8'd0 ||
        delta_x !== 9'sd0 || tick !== 2'b00) begin
      bad++;
      $display("FAIL mid_rst: state=%0d score=%0d dx=%0d tick=%b, want 0",
               game_state, score, delta_x, tick);
    end
    for (int n = 2; n <= 12; n++) begin
      @(negedge clk);
      exp_s = (n >= 8) ? S_PLAY : S_IDLE;
      exp_t = (n == 10);
      total++;
      if (game_state !== exp_s || tick[0] !== exp_t) begin
        bad++;
        $display("FAIL rst_phase c%0d: state=%0d tick0=%b, want %0d/%b",
                 n, game_state, tick[0], exp_s, exp_t);
      end
    end
    button_start = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_idle_ticks();
    test_glitch();
    test_start();
    test_move();
    test_score();
    test_over();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
